white_balance_ctrl: RTL and testbench
=====================================

# white_balance_ctrl

Two-pass frame sequencer for the white-balance pixel datapath. Pass 1 streams a frame of 32-bit {A,R,G,B} pixels from memory and builds a per-channel running maximum, the white reference. Pass 2 re-reads each pixel, routes it and the white reference through the external combinational white-balance datapath, and writes the result to a destination buffer. The block sits between the frame-buffer memory port and the image-processing top level, and is launched by a start pulse.

## Interface
- ADDR_W, 16, memory word-address width
- CNT_W, 16, pixel-count width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  launch pulse; sampled only in IDLE
- src_base  in  ADDR_W  source frame base address; latched on accepted start
- dst_base  in  ADDR_W  destination base address; latched on accepted start
- pixel_count  in  CNT_W  number of pixels; latched on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse when the frame is complete
- white  out  32  {8'h00,Rmax,Gmax,Bmax}; updated at end of scan; held until the next scan completes
- mem_req  out  1  transaction request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; valid in the ack cycle
- mem_ack  in  1  transaction completes in a cycle where mem_req && mem_ack
- dp_pixel  out  32  pixel presented to the datapath
- dp_white  out  32  white reference presented to the datapath (equals white)
- dp_result  in  32  combinational datapath result

## Operation
- States: IDLE, SCAN, APPLY_RD, APPLY_WR, DONE.
- IDLE:
  - start = 1 latches the bases and count, clears the running max to 0, and moves to SCAN.
  - If pixel_count == 0, go to DONE instead; there is no memory traffic and white is unchanged.
- SCAN:
  - mem_req = 1, mem_we = 0, mem_addr = src_base + idx.
  - On ack, each of R/G/B max is updated with mem_rdata[23:16], [15:8] and [7:0] (unsigned compare). Alpha is ignored.
  - idx increments on each ack. On the ack of the last pixel (idx == count-1), white is loaded with the final maxima, idx is cleared, and the state moves to APPLY_RD.
  - Any channel whose max is 0 is stored as 8'hFF.
- APPLY_RD:
  - Read at src_base + idx. On ack, pix_reg <= mem_rdata and the state moves to APPLY_WR.
- APPLY_WR:
  - mem_we = 1, mem_addr = dst_base + idx, mem_wdata = dp_result.
  - dp_pixel = pix_reg at all times.
  - On ack: if this is the last pixel, go to DONE; otherwise idx++ and go to APPLY_RD.
- DONE: done = 1 for one cycle, busy = 0, then return to IDLE.
- start is ignored while not in IDLE.
- Address arithmetic wraps modulo 2^ADDR_W.
- src_base == dst_base (in-place operation) is legal, because each pixel is read before it is written.

## Timing
- Reset values:
  - state IDLE; busy = 0, done = 0, mem_req = 0, mem_we = 0.
  - mem_addr = 0, mem_wdata = 0 (only when mem_req = 0), white = 32'h0, idx = 0.
- Reset mid-operation: the next cycle is IDLE with mem_req = 0. A late mem_ack in IDLE is ignored. white reverts to 0.
- mem_req, mem_we, mem_addr and mem_wdata are registered/state-derived and stay stable from request until ack.
- After an ack, the next request may be presented in the very next cycle; there is no mandatory idle cycle.
- With a memory that acks in the same cycle as the request, for start sampled at cycle 0:
  - SCAN occupies cycles 1..N.
  - APPLY occupies cycles N+1..3N.
  - done pulses in cycle 3N+1; busy is high in cycles 1..3N.
  - white is valid from cycle N+1.
- Each wait cycle (req high, ack low) extends the schedule by exactly one cycle.
- Count-zero case: start at cycle 0 gives done in cycle 1 and busy never rises.

## Structure
- Package wb_ctrl_pkg:
  - state enum wb_state_t.
  - packed struct pixel_t {a,r,g,b} of 8 bits each.
  - constant WB_ZERO_SUB = 8'hFF.
- Sub-module wb_max_tracker:
  - three 8-bit running-max registers.
  - inputs clk, rst, clear, en, pixel; output the current maxima.
- Control logic lives in the top module: FSM, idx counter, address muxing, latching of bases and count.
- The datapath is not instantiated here; the parent wires dp_* to it.

## Test plan
- Four-pixel frame, same-cycle ack:
  - Stimulus: src = {00102030, 00405060, 00807010, 00204080}.
  - Required: white = 00807080 at cycle 5; four writes of dp_result to dst..dst+3; done at cycle 13.
- Random 0-3 cycle ack delays on a 64-pixel frame:
  - Required: the address sequence is 64 reads, then 64 alternating read/write pairs; each transaction is held stable until ack; done follows the final write ack.
- Frame with all B = 0:
  - Required: white[7:0] = FF and the other channels are the true maxima.
- pixel_count = 0:
  - Required: done in cycle 1, zero mem_req cycles, white unchanged.
- Illegal start and mid-frame reset:
  - Stimulus: start pulsed during SCAN.
  - Required: the start is ignored.
  - Stimulus: rst asserted mid-APPLY_WR with a stalled ack.
  - Required: the next cycle shows IDLE, mem_req = 0, white = 0; a subsequent clean start completes normally.
- In-place operation:
  - Stimulus: src_base == dst_base, with the address wrapping past FFFF.
  - Required: every location is read before it is written, and the addresses wrap to 0000.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared types and helpers for the white-balance frame sequencer.
package wb_ctrl_pkg;
  typedef enum logic [2:0] {
    WB_IDLE, WB_SCAN, WB_APPLY_RD, WB_APPLY_WR, WB_DONE
  } wb_state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam logic [7:0] WB_ZERO_SUB = 8'hFF;

  function automatic logic [7:0] max8(input logic [7:0] x, input logic [7:0] y);
    return (x > y) ? x : y;
  endfunction

  // An all-zero channel would divide by zero downstream, so it reads as full scale.
  function automatic logic [7:0] zsub(input logic [7:0] x);
    return (x == 8'd0) ? WB_ZERO_SUB : x;
  endfunction
endpackage

// File: rtl/wb_max_tracker.sv
// Per-channel running maximum over the R/G/B bytes of a pixel stream.
module wb_max_tracker import wb_ctrl_pkg::*; (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   en,
  input  pixel_t pixel,
  output pixel_t maxv
);
  logic unused_alpha;
  assign unused_alpha = ^pixel.a;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      maxv <= '0;
    end else if (en) begin
      maxv.r <= max8(maxv.r, pixel.r);
      maxv.g <= max8(maxv.g, pixel.g);
      maxv.b <= max8(maxv.b, pixel.b);
    end
  end
endmodule

// File: rtl/white_balance_ctrl.sv
// Two-pass frame sequencer: scan for the white reference, then read/apply/write each pixel.
module white_balance_ctrl import wb_ctrl_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [CNT_W-1:0]  pixel_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       white,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       dp_pixel,
  output logic [31:0]       dp_white,
  input  logic [31:0]       dp_result
);
  wb_state_t         state;
  logic [CNT_W-1:0]  idx, cnt_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [31:0]       pix_reg;
  pixel_t            mx, rpx;
  logic              last, scan_ack, start_ok;

  assign rpx      = pixel_t'(mem_rdata);
  assign last     = (idx == cnt_q - CNT_W'(1));
  assign scan_ack = (state == WB_SCAN) && mem_ack;
  assign start_ok = (state == WB_IDLE) && start;

  wb_max_tracker u_max (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (scan_ack),
    .pixel (rpx),
    .maxv  (mx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WB_IDLE;
      idx     <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      pix_reg <= '0;
      white   <= '0;
    end else begin
      case (state)
        WB_IDLE: if (start) begin
          src_q <= src_base;
          dst_q <= dst_base;
          cnt_q <= pixel_count;
          idx   <= '0;
          state <= (pixel_count == '0) ? WB_DONE : WB_SCAN;
        end
        WB_SCAN: if (mem_ack) begin
          if (last) begin
            // Fold in the final pixel here; the tracker only sees it next cycle.
            white <= {8'h00, zsub(max8(mx.r, rpx.r)), zsub(max8(mx.g, rpx.g)),
                      zsub(max8(mx.b, rpx.b))};
            idx   <= '0;
            state <= WB_APPLY_RD;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        WB_APPLY_RD: if (mem_ack) begin
          pix_reg <= mem_rdata;
          state   <= WB_APPLY_WR;
        end
        WB_APPLY_WR: if (mem_ack) begin
          if (last) begin
            state <= WB_DONE;
          end else begin
            idx   <= idx + CNT_W'(1);
            state <= WB_APPLY_RD;
          end
        end
        WB_DONE: state <= WB_IDLE;
        default: state <= WB_IDLE;
      endcase
    end
  end

  // Bus outputs derive only from registered state, so they hold steady across waits.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      WB_SCAN, WB_APPLY_RD: begin
        mem_req  = 1'b1;
        mem_addr = src_q + ADDR_W'(idx);
      end
      WB_APPLY_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_q + ADDR_W'(idx);
        mem_wdata = dp_result;
      end
      default: ;
    endcase
  end

  assign busy     = (state == WB_SCAN) || (state == WB_APPLY_RD) || (state == WB_APPLY_WR);
  assign done     = (state == WB_DONE);
  assign dp_pixel = pix_reg;
  assign dp_white = white;
endmodule

// File: tb/tb_white_balance_ctrl.sv
// Randomized bench: memory/datapath model with random ack delay, frame-level reference model.
module tb_white_balance_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic [15:0] src_base = 0, dst_base = 0, pixel_count = 0;
  logic        busy, done, mem_req, mem_we, mem_ack = 0;
  logic [31:0] white, mem_wdata, mem_rdata = 0, dp_pixel, dp_white, dp_result;
  logic [15:0] mem_addr;

  white_balance_ctrl #(.ADDR_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .pixel_count(pixel_count), .busy(busy), .done(done), .white(white),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dp_pixel(dp_pixel), .dp_white(dp_white),
    .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  // Stand-in for the external datapath.
  assign dp_result = dp_pixel + dp_white;

  typedef struct { bit we; logic [15:0] addr; logic [31:0] data; } txn_t;

  logic [31:0] mem [0:65535];
  logic [31:0] px [$];
  txn_t        tlog [$];
  int          tests = 0, fails = 0;
  int          cyc = 0, last_ack = 0, start_cyc = 0;
  int          max_delay = 0, wcnt = 0;
  bit          stall_wr = 0, in_txn = 0;
  logic [15:0] h_addr;
  logic        h_we;
  logic [31:0] h_wd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory responder: decides ack and read data mid-cycle, checks bus stability while waiting.
  always @(negedge clk) begin
    if (mem_req) begin
      if (!in_txn) begin
        in_txn = 1;
        h_addr = mem_addr; h_we = mem_we; h_wd = mem_wdata;
        wcnt = $urandom_range(0, max_delay);
      end else begin
        chk("hold_addr", {16'h0, mem_addr}, {16'h0, h_addr});
        chk("hold_we", {31'h0, mem_we}, {31'h0, h_we});
        chk("hold_wdata", mem_wdata, h_wd);
      end
      mem_ack = !(stall_wr && mem_we) && (wcnt == 0);
      if (wcnt > 0) wcnt--;
      mem_rdata = mem[mem_addr];
    end else begin
      in_txn = 0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack) begin
      txn_t t;
      t.we = mem_we; t.addr = mem_addr; t.data = mem_we ? mem_wdata : mem_rdata;
      tlog.push_back(t);
      if (mem_we) mem[mem_addr] = mem_wdata;
      last_ack = cyc;
      in_txn = 0;
    end
    cyc++;
  end

  task automatic load_frame(input logic [15:0] s, input int n, input bit zero_b);
    px.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] v = $urandom;
      if (zero_b) v[7:0] = 8'h00;
      px.push_back(v);
      mem[s + 16'(i)] = v;
    end
  endtask

  function automatic logic [31:0] ref_white();
    logic [7:0] r = 0, g = 0, b = 0;
    foreach (px[i]) begin
      if (px[i][23:16] > r) r = px[i][23:16];
      if (px[i][15:8]  > g) g = px[i][15:8];
      if (px[i][7:0]   > b) b = px[i][7:0];
    end
    return {8'h00, (r == 0) ? 8'hFF : r, (g == 0) ? 8'hFF : g, (b == 0) ? 8'hFF : b};
  endfunction

  task automatic run_frame(input logic [15:0] s, input logic [15:0] d, input int n,
                           input int maxd, input bit glitch,
                           output int done_rel, output int reqs, output logic [31:0] w_n1);
    bit got = 0;
    int rel;
    tlog.delete();
    max_delay = maxd; reqs = 0; done_rel = -1; w_n1 = 32'hDEAD_BEEF;
    @(negedge clk);
    src_base = s; dst_base = d; pixel_count = 16'(n); start = 1;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      rel = cyc - start_cyc;
      if (glitch && rel == 3) begin
        start = 1; src_base = s + 16'h0100; dst_base = d + 16'h0200; pixel_count = 5;
      end else if (glitch && rel == 4) begin
        start = 0;
      end
      if (rel == n + 1) w_n1 = white;
      if (mem_req) reqs++;
      if (done) begin
        got = 1; done_rel = rel;
        chk("busy_at_done", {31'h0, busy}, 32'h0);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_frame(input logic [15:0] s, input logic [15:0] d, input int n,
                             input int done_rel);
    logic [31:0] ew = ref_white();
    chk("white", white, ew);
    chk("txn_count", tlog.size(), 3 * n);
    if (tlog.size() == 3 * n) begin
      for (int i = 0; i < n; i++) begin
        chk("scan_addr", {tlog[i].we, 15'h0, tlog[i].addr}, {16'h0, s + 16'(i)});
        chk("rd_addr", {tlog[n+2*i].we, 15'h0, tlog[n+2*i].addr}, {16'h0, s + 16'(i)});
        chk("rd_data", tlog[n+2*i].data, px[i]);
        chk("wr_addr", {tlog[n+2*i+1].we, 15'h0, tlog[n+2*i+1].addr}, {16'h8000, d + 16'(i)});
        chk("wr_data", tlog[n+2*i+1].data, px[i] + ew);
      end
    end
    for (int i = 0; i < n; i++) chk("dst_mem", mem[d + 16'(i)], px[i] + ew);
    chk("done_after_last_ack", done_rel, last_ack - start_cyc + 1);
  endtask

  initial begin
    int dr, rq;
    logic [31:0] w1, wprev;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_req", {31'h0, mem_req}, 0);
    chk("rst_we", {31'h0, mem_we}, 0);
    chk("rst_addr", {16'h0, mem_addr}, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_white", white, 0);
    rst = 0;

    // Directed four-pixel frame with same-cycle ack.
    px = '{32'h00102030, 32'h00405060, 32'h00807010, 32'h00204080};
    foreach (px[i]) mem[16'h0100 + 16'(i)] = px[i];
    run_frame(16'h0100, 16'h0200, 4, 0, 0, dr, rq, w1);
    chk("dir_white_n1", w1, 32'h00807080);
    chk("dir_done_cyc", dr, 13);
    check_frame(16'h0100, 16'h0200, 4, dr);

    // 64 pixels, random 0..3 wait states.
    load_frame(16'h1000, 64, 0);
    run_frame(16'h1000, 16'h3000, 64, 3, 0, dr, rq, w1);
    check_frame(16'h1000, 16'h3000, 64, dr);

    // Blue channel all zero.
    load_frame(16'h4000, 20, 1);
    run_frame(16'h4000, 16'h5000, 20, 2, 0, dr, rq, w1);
    chk("zero_b_sub", {24'h0, white[7:0]}, 32'hFF);
    check_frame(16'h4000, 16'h5000, 20, dr);

    // Zero-length frame.
    wprev = white;
    run_frame(16'h6000, 16'h7000, 0, 0, 0, dr, rq, w1);
    chk("cnt0_done_cyc", dr, 1);
    chk("cnt0_reqs", rq, 0);
    chk("cnt0_white", white, wprev);

    // Start pulsed during SCAN must not disturb the frame.
    load_frame(16'h2000, 12, 0);
    run_frame(16'h2000, 16'h2800, 12, 1, 1, dr, rq, w1);
    check_frame(16'h2000, 16'h2800, 12, dr);

    // Reset during a stalled write.
    load_frame(16'h8000, 6, 0);
    stall_wr = 1; max_delay = 0; seen = 0;
    @(negedge clk);
    src_base = 16'h8000; dst_base = 16'h9000; pixel_count = 6; start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (mem_req && mem_we) seen = 1;
      else @(negedge clk);
    end
    chk("stall_wr_reached", {31'h0, seen}, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("mrst_req", {31'h0, mem_req}, 0);
    chk("mrst_busy", {31'h0, busy}, 0);
    chk("mrst_white", white, 0);
    rst = 0; stall_wr = 0;
    load_frame(16'h8000, 6, 0);
    run_frame(16'h8000, 16'h9000, 6, 1, 0, dr, rq, w1);
    check_frame(16'h8000, 16'h9000, 6, dr);

    // In place, wrapping past FFFF.
    load_frame(16'hFFF0, 40, 0);
    run_frame(16'hFFF0, 16'hFFF0, 40, 2, 0, dr, rq, w1);
    check_frame(16'hFFF0, 16'hFFF0, 40, dr);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
